svi_controller: RTL and testbench

SVI_CONTROLLER -- requirements
Module: svi_controller

---
 rtl/svi_ctrl_pkg.sv | 20 ++
 rtl/svi_progress_watchdog.sv | 50 +++++
 rtl/svi_controller.sv | 152 +++++++++++++++
 tb/tb_svi_controller.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svi_ctrl_pkg.sv
// Shared types and constants for the SVI run controller and its progress watchdog.
package svi_ctrl_pkg;

    localparam int WD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'b00,
        FC_ERR     = 2'b01,
        FC_TIMEOUT = 2'b10,
        FC_WRAP    = 2'b11
    } fault_code_t;

endpackage

// File: rtl/svi_progress_watchdog.sv
// Tracks count2 across RUN cycles: change/decrease detection and a stall timeout counter.
module svi_progress_watchdog
    import svi_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       run,
    input  logic [7:0] count2,
    output logic       decreased,
    output logic       expired
);

    localparam logic [WD_W:0] LIMIT = (WD_W+1)'(TIMEOUT_CYCLES);

    logic [7:0]      prev_q;
    logic            valid_q;
    logic [WD_W-1:0] wd_q;
    logic [WD_W:0]   wd_inc;
    logic            changed;

    // The first RUN cycle has no predecessor, so it neither counts as a change nor a stall.
    assign changed   = valid_q && (count2 != prev_q);
    assign decreased = valid_q && (count2 < prev_q);
    assign wd_inc    = {1'b0, wd_q} + {{WD_W{1'b0}}, 1'b1};
    assign expired   = (TIMEOUT_CYCLES != 0) && run && valid_q && !changed && (wd_inc == LIMIT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q  <= 8'd0;
            valid_q <= 1'b0;
            wd_q    <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            wd_q    <= '0;
        end else if (run) begin
            prev_q  <= count2;
            valid_q <= 1'b1;
            if (!valid_q || changed) begin
                wd_q <= '0;
            end else if (wd_q != '1) begin
                wd_q <= wd_inc[WD_W-1:0];
            end
        end
    end

endmodule

// File: rtl/svi_controller.sv
// Run controller for a counting master: start/abort, completion, sticky faults, watchdog.
// Optional run statistics ports are enabled with `define SVI_CONTROLLER_STATS_EN.
module svi_controller
    import svi_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  target,
    input  logic        abort,
    input  logic        fault_clr,
    output logic        enable,
    input  logic        error,
    input  logic [7:0]  count2,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [7:0]  final_count
`ifdef SVI_CONTROLLER_STATS_EN
    ,
    output logic [15:0] runs_ok,
    output logic [15:0] runs_fault
`endif
);

    state_t      state_q, state_d;
    fault_code_t code_q, code_d;
    logic        enable_d, busy_d, done_d, fault_d;
    logic [7:0]  final_d, target_q, target_d;
    logic        wd_clear, decreased, expired;

    svi_progress_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear     (wd_clear),
        .run       (state_q == ST_RUN),
        .count2    (count2),
        .decreased (decreased),
        .expired   (expired)
    );

    assign fault_code = code_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        enable_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        fault_d  = fault;
        code_d   = code_q;
        final_d  = final_count;
        target_d = target_q;
        wd_clear = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    target_d = target;
                    if (target != 8'd0) begin
                        state_d  = ST_RUN;
                        enable_d = 1'b1;
                        busy_d   = 1'b1;
                        wd_clear = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        final_d = count2;
                    end
                end
            end
            ST_RUN: begin
                // Exits drop enable/busy as the new state is entered; priority is fixed below.
                final_d = count2;
                if (error) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = FC_ERR;
                end else if (abort) begin
                    state_d = ST_IDLE;
                end else if (decreased) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = FC_WRAP;
                end else if (count2 >= target_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (expired) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = FC_TIMEOUT;
                end else begin
                    final_d  = final_count;
                    enable_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            enable      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            code_q      <= FC_NONE;
            final_count <= 8'd0;
            target_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            enable      <= enable_d;
            busy        <= busy_d;
            done        <= done_d;
            fault       <= fault_d;
            code_q      <= code_d;
            final_count <= final_d;
            target_q    <= target_d;
        end
    end

`ifdef SVI_CONTROLLER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            runs_ok    <= 16'd0;
            runs_fault <= 16'd0;
        end else begin
            if (done_d && (runs_ok != 16'hFFFF)) begin
                runs_ok <= runs_ok + 16'd1;
            end
            if ((state_d == ST_FAULT) && (state_q != ST_FAULT) && (runs_fault != 16'hFFFF)) begin
                runs_fault <= runs_fault + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_svi_controller.sv
// Scoreboard bench for svi_controller: stimulus queues expected run outcomes, a monitor checks them.
module tb_svi_controller;

    typedef struct packed {
        logic       done;
        logic       fault;
        logic [1:0] code;
        logic [7:0] fin;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  target;
    logic        abort;
    logic        fault_clr;
    logic        enable;
    logic        error;
    logic [7:0]  count2;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;
    logic [7:0]  final_count;
`ifdef SVI_CONTROLLER_STATS_EN
    logic [15:0] runs_ok;
    logic [15:0] runs_fault;
`endif

    int   total = 0;
    int   passed = 0;
    int   en_cnt;
    exp_t sb_q[$];
    exp_t mon_e;
    bit   busy_prev = 1'b0;
    bit   fault_prev = 1'b0;

    svi_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .target      (target),
        .abort       (abort),
        .fault_clr   (fault_clr),
        .enable      (enable),
        .error       (error),
        .count2      (count2),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .fault_code  (fault_code),
        .final_count (final_count)
`ifdef SVI_CONTROLLER_STATS_EN
        ,
        .runs_ok     (runs_ok),
        .runs_fault  (runs_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_end(input logic d, input logic f, input logic [1:0] c, input logic [7:0] fin);
        exp_t e;
        e.done  = d;
        e.fault = f;
        e.code  = c;
        e.fin   = fin;
        sb_q.push_back(e);
    endtask

    // Monitor: a run ends on a done pulse, a fault rising, or busy falling with neither.
    always @(negedge clk) begin
        if (done === 1'b1 || (fault === 1'b1 && !fault_prev) ||
            (busy_prev && busy === 1'b0 && done === 1'b0 && fault === 1'b0)) begin
            if (sb_q.size() == 0) begin
                total++;
                $display("FAIL sb_unexpected: run-end event with empty queue (done=%0b fault=%0b)", done, fault);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_done",        {15'd0, done},        {15'd0, mon_e.done});
                check("sb_fault",       {15'd0, fault},       {15'd0, mon_e.fault});
                check("sb_fault_code",  {14'd0, fault_code},  {14'd0, mon_e.code});
                check("sb_final_count", {8'd0, final_count},  {8'd0, mon_e.fin});
                check("sb_enable_low",  {15'd0, enable},      16'd0);
            end
        end
        busy_prev  = (busy === 1'b1);
        fault_prev = (fault === 1'b1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; target = 8'd0; abort = 1'b0;
        fault_clr = 1'b0; error = 1'b0; count2 = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_enable",      {15'd0, enable},     16'd0);
        check("rst_busy",        {15'd0, busy},       16'd0);
        check("rst_done",        {15'd0, done},       16'd0);
        check("rst_fault",       {15'd0, fault},      16'd0);
        check("rst_fault_code",  {14'd0, fault_code}, 16'd0);
        check("rst_final_count", {8'd0, final_count}, 16'd0);
        step();
        reset = 1'b0;
        step();

        // Normal run: target 5, count2 steps 0..5.
        expect_end(1'b1, 1'b0, 2'b00, 8'd5);
        start = 1'b1; target = 8'd5; count2 = 8'd0;
        step();
        start = 1'b0;
        en_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            count2 = (k < 5) ? 8'(k) : 8'd5;
            @(negedge clk);
            en_cnt += int'(enable);
            step();
        end
        check("run5_enable_cycles", 16'(en_cnt), 16'd6);
        check("run5_fault", {15'd0, fault}, 16'd0);

        // Zero target: immediate done, enable never asserted.
        count2 = 8'd77;
        expect_end(1'b1, 1'b0, 2'b00, 8'd77);
        start = 1'b1; target = 8'd0;
        step();
        start = 1'b0;
        @(negedge clk);
        check("t0_done_pulse", {15'd0, done},   16'd1);
        check("t0_enable",     {15'd0, enable}, 16'd0);
        @(negedge clk);
        check("t0_done_cleared", {15'd0, done},   16'd0);
        check("t0_enable_after", {15'd0, enable}, 16'd0);
        step();

        // Stall timeout: count2 stuck at 3, TIMEOUT_CYCLES=4.
        count2 = 8'd3;
        expect_end(1'b0, 1'b1, 2'b10, 8'd3);
        start = 1'b1; target = 8'd10;
        step();
        start = 1'b0;
        en_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            en_cnt += int'(enable);
            step();
        end
        check("to_enable_cycles", 16'(en_cnt),         16'd5);
        check("to_fault_sticky",  {15'd0, fault},      16'd1);
        check("to_code_sticky",   {14'd0, fault_code}, 16'd2);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        @(negedge clk);
        check("to_clr_fault", {15'd0, fault},      16'd0);
        check("to_clr_code",  {14'd0, fault_code}, 16'd0);
        check("to_clr_busy",  {15'd0, busy},       16'd0);
        step();

        // Abort: back to idle, no fault, no done.
        count2 = 8'd0;
        expect_end(1'b0, 1'b0, 2'b00, 8'd2);
        start = 1'b1; target = 8'd50;
        step();
        start = 1'b0; count2 = 8'd1;
        step();
        count2 = 8'd2; abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("ab_enable", {15'd0, enable}, 16'd0);
        check("ab_fault",  {15'd0, fault},  16'd0);
        step();

        // Error and abort together: error wins.
        count2 = 8'd10;
        expect_end(1'b0, 1'b1, 2'b01, 8'd12);
        start = 1'b1; target = 8'd20;
        step();
        start = 1'b0; count2 = 8'd11;
        step();
        count2 = 8'd12; error = 1'b1; abort = 1'b1;
        step();
        error = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("ea_enable", {15'd0, enable},     16'd0);
        check("ea_code",   {14'd0, fault_code}, 16'd1);
        step();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        step();

        // Wrap: 250 then 2 with target 255; start during FAULT ignored.
        count2 = 8'd250;
        expect_end(1'b0, 1'b1, 2'b11, 8'd2);
        start = 1'b1; target = 8'd255;
        step();
        start = 1'b0;
        step();
        count2 = 8'd2;
        step();
        start = 1'b1; target = 8'd5;
        step();
        start = 1'b0;
        @(negedge clk);
        check("wr_fault_held", {15'd0, fault},      16'd1);
        check("wr_code",       {14'd0, fault_code}, 16'd3);
        check("wr_start_busy", {15'd0, busy},       16'd0);
        check("wr_start_en",   {15'd0, enable},     16'd0);
        step();
        fault_clr = 1'b1; start = 1'b1;
        step();
        fault_clr = 1'b0; start = 1'b0;
        @(negedge clk);
        check("wr_clr_fault", {15'd0, fault},      16'd0);
        check("wr_clr_code",  {14'd0, fault_code}, 16'd0);
        @(negedge clk);
        check("wr_clr_start_ignored", {15'd0, busy}, 16'd0);
        step();

        // Reset in the third RUN cycle discards the run.
        count2 = 8'd0;
        expect_end(1'b0, 1'b0, 2'b00, 8'd0);
        start = 1'b1; target = 8'd100;
        step();
        start = 1'b0; count2 = 8'd1;
        step();
        count2 = 8'd2;
        step();
        count2 = 8'd3; reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("mr_enable", {15'd0, enable},     16'd0);
        check("mr_busy",   {15'd0, busy},       16'd0);
        check("mr_done",   {15'd0, done},       16'd0);
        check("mr_fault",  {15'd0, fault},      16'd0);
        check("mr_code",   {14'd0, fault_code}, 16'd0);
        check("mr_final",  {8'd0, final_count}, 16'd0);
        repeat (3) begin
            @(negedge clk);
            check("mr_no_done", {15'd0, done}, 16'd0);
        end
        step();

`ifdef SVI_CONTROLLER_STATS_EN
        check("st_ok_reset",    runs_ok,    16'd0);
        check("st_fault_reset", runs_fault, 16'd0);
        for (int i = 0; i < 3; i++) begin
            count2 = 8'(i + 1);
            expect_end(1'b1, 1'b0, 2'b00, 8'(i + 1));
            start = 1'b1; target = 8'd0;
            step();
            start = 1'b0;
            step();
            step();
        end
        check("st_runs_ok",    runs_ok,    16'd3);
        check("st_runs_fault", runs_fault, 16'd0);
`endif

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        check("sb_drained", 16'(sb_q.size()), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
